alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU.
// One operation in flight at a time: grant/drive in IDLE, capture result in EXEC.
module alu_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [3:0]   i_u4_op0,
  input  logic [3:0]   i_u4_op1,
  input  logic [W-1:0] i_u32_a0,
  input  logic [W-1:0] i_u32_b0,
  input  logic [W-1:0] i_u32_a1,
  input  logic [W-1:0] i_u32_b1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_done0,
  output logic         o_done1,
  output logic [W-1:0] o_u32_dout,
  output logic         o_zf,
  output logic         o_err,
  output logic         o_busy,
  output logic [3:0]   o_u4_alu_op,
  output logic [W-1:0] o_u32_alu_din1,
  output logic [W-1:0] o_u32_alu_din2,
  input  logic [W-1:0] i_u32_alu_dout,
  input  logic         i_alu_zf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]   state;
  logic         last_gnt;   // port served most recently; also the port owning EXEC
  logic         illegal;
  logic         req_any;
  logic         sel;
  logic         sel_legal;
  logic [3:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;

  always_comb begin
    req_any = i_req0 | i_req1;
    sel     = 1'b0;
    if (i_req0 && i_req1) sel = ~last_gnt;
    else                  sel = i_req1;
    sel_op = sel ? i_u4_op1 : i_u4_op0;
    sel_a  = sel ? i_u32_a1 : i_u32_a0;
    sel_b  = sel ? i_u32_b1 : i_u32_b0;
    case (sel_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: sel_legal = 1'b1;
      default:                                               sel_legal = 1'b0;
    endcase
  end

  assign o_busy = (state == EXEC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      last_gnt       <= 1'b1;
      illegal        <= 1'b0;
      o_gnt0         <= 1'b0;
      o_gnt1         <= 1'b0;
      o_done0        <= 1'b0;
      o_done1        <= 1'b0;
      o_u32_dout     <= '0;
      o_zf           <= 1'b0;
      o_err          <= 1'b0;
      o_u4_alu_op    <= '0;
      o_u32_alu_din1 <= '0;
      o_u32_alu_din2 <= '0;
    end else begin
      o_gnt0  <= 1'b0;
      o_gnt1  <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state    <= EXEC;
            o_gnt0   <= ~sel;
            o_gnt1   <= sel;
            last_gnt <= sel;
            illegal  <= ~sel_legal;
            // Unsupported opcodes present a benign AND of zeros to the shared ALU.
            if (sel_legal) begin
              o_u4_alu_op    <= sel_op;
              o_u32_alu_din1 <= sel_a;
              o_u32_alu_din2 <= sel_b;
            end else begin
              o_u4_alu_op    <= '0;
              o_u32_alu_din1 <= '0;
              o_u32_alu_din2 <= '0;
            end
          end
        end
        EXEC: begin
          state      <= IDLE;
          o_u32_dout <= illegal ? '0 : i_u32_alu_dout;
          o_zf       <= illegal ? 1'b0 : i_alu_zf;
          o_err      <= illegal;
          o_done0    <= ~last_gnt;
          o_done1    <= last_gnt;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [3:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, zf, err, busy;
  logic [W-1:0] dout, din1, din2, alu_dout;
  logic [3:0]   alu_op;
  logic         alu_zf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1),
    .i_u4_op0(op0), .i_u4_op1(op1),
    .i_u32_a0(a0), .i_u32_b0(b0), .i_u32_a1(a1), .i_u32_b1(b1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_u32_dout(dout), .o_zf(zf), .o_err(err), .o_busy(busy),
    .o_u4_alu_op(alu_op), .o_u32_alu_din1(din1), .o_u32_alu_din2(din2),
    .i_u32_alu_dout(alu_dout), .i_alu_zf(alu_zf)
  );

  // Shared ALU as seen by the arbiter
  always_comb begin
    alu_dout = '0;
    case (alu_op)
      4'b0000: alu_dout = din1 & din2;
      4'b0001: alu_dout = din1 | din2;
      4'b0010: alu_dout = din1 + din2;
      4'b0110: alu_dout = din1 - din2;
      4'b0111: alu_dout = (din1 < din2) ? 32'd1 : 32'd0;
      4'b1100: alu_dout = ~(din1 | din2);
      default: alu_dout = '0;
    endcase
    alu_zf = (alu_dout == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input string tag, input logic g0, input logic g1,
                        input logic d0, input logic d1);
    chk({tag, ".gnt0"}, gnt0, g0);
    chk({tag, ".gnt1"}, gnt1, g1);
    chk({tag, ".done0"}, done0, d0);
    chk({tag, ".done1"}, done1, d1);
  endtask

  task automatic result(input string tag, input logic [31:0] d, input logic z, input logic e);
    chk({tag, ".dout"}, dout, d);
    chk({tag, ".zf"}, zf, z);
    chk({tag, ".err"}, err, e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(gnt0 && gnt1) && !(done0 && done1)) else begin
        bad++;
        $error("FAIL exclusive observed=%b%b%b%b expected=no pair", gnt0, gnt1, done0, done1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; op0 = '0; op1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) tick();
    pulses("rst", 0, 0, 0, 0);
    result("rst", 0, 0, 0);
    chk("rst.busy", busy, 0);
    chk("rst.aluop", alu_op, 0);
    rst_n = 1'b1;

    // single request ADD 5+7
    req0 = 1; op0 = 4'b0010; a0 = 5; b0 = 7;
    tick();
    pulses("add.g", 1, 0, 0, 0);
    chk("add.busy", busy, 1);
    chk("add.aluop", alu_op, 4'b0010);
    chk("add.din1", din1, 5);
    chk("add.din2", din2, 7);
    req0 = 0;
    tick();
    pulses("add.d", 0, 0, 1, 0);
    result("add", 12, 0, 0);
    chk("add.busy_d", busy, 0);
    tick();
    pulses("add.h", 0, 0, 0, 0);
    result("add.hold", 12, 0, 0);

    // zero flag via SUB, then unsigned SLT issued during done cycle
    req1 = 1; op1 = 4'b0110; a1 = 32'h1234; b1 = 32'h1234;
    tick();
    pulses("sub.g", 0, 1, 0, 0);
    op1 = 4'b0111; a1 = 3; b1 = 9;
    tick();
    pulses("sub.d", 0, 0, 0, 1);
    result("sub", 0, 1, 0);
    tick();
    pulses("slt.g", 0, 1, 0, 0);
    req1 = 0;
    tick();
    pulses("slt.d", 0, 0, 0, 1);
    result("slt", 1, 0, 0);

    // unsupported opcode
    req0 = 1; op0 = 4'b1111; a0 = 1; b0 = 1;
    tick();
    pulses("ill.g", 1, 0, 0, 0);
    chk("ill.aluop", alu_op, 0);
    chk("ill.din1", din1, 0);
    chk("ill.din2", din2, 0);
    req0 = 0;
    tick();
    pulses("ill.d", 0, 0, 1, 0);
    result("ill", 0, 0, 1);

    // reset during EXEC of a port 1 NOR
    req1 = 1; op1 = 4'b1100; a1 = 32'hF0; b1 = 32'h0F;
    tick();
    pulses("nor.g", 0, 1, 0, 0);
    chk("nor.aluop", alu_op, 4'b1100);
    req1 = 0;
    #2 rst_n = 1'b0;
    #1;
    pulses("mid.rst", 0, 0, 0, 0);
    result("mid.rst", 0, 0, 0);
    chk("mid.busy", busy, 0);
    chk("mid.aluop", alu_op, 0);
    chk("mid.din1", din1, 0);
    #1 rst_n = 1'b1;
    tick();
    pulses("mid.nodone", 0, 0, 0, 0);

    // first contention after reset goes to port 0; port 1 follows
    req0 = 1; op0 = 4'b0010; a0 = 1; b0 = 1;
    req1 = 1; op1 = 4'b0001; a1 = 32'h30; b1 = 32'h03;
    tick();
    pulses("pr.g0", 1, 0, 0, 0);
    req0 = 0;
    tick();
    pulses("pr.d0", 0, 0, 1, 0);
    chk("pr.dout0", dout, 2);
    tick();
    pulses("pr.g1", 0, 1, 0, 0);
    req1 = 0;
    tick();
    pulses("pr.d1", 0, 0, 0, 1);
    chk("pr.dout1", dout, 32'h33);

    // request arriving during EXEC waits for IDLE
    req0 = 1; op0 = 4'b0010; a0 = 10; b0 = 20;
    tick();
    pulses("late.g0", 1, 0, 0, 0);
    req0 = 0;
    #1 req1 = 1; op1 = 4'b0110; a1 = 9; b1 = 4;
    tick();
    pulses("late.d0", 0, 0, 1, 0);
    chk("late.dout0", dout, 30);
    tick();
    pulses("late.g1", 0, 1, 0, 0);
    req1 = 0;
    tick();
    pulses("late.d1", 0, 0, 0, 1);
    chk("late.dout1", dout, 5);

    // sustained contention from reset: 0,1,0,1 one grant per two cycles
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req0 = 1; op0 = 4'b0000; a0 = 32'hFF; b0 = 32'h0F;
    req1 = 1; op1 = 4'b0001; a1 = 32'hF0; b1 = 32'h0F;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        pulses("rr.g", (k % 4 == 0), (k % 4 == 2), 0, 0);
        if (k == 6) begin
          req0 = 0;
          req1 = 0;
        end
      end else begin
        pulses("rr.d", 0, 0, (k % 4 == 1), (k % 4 == 3));
        chk("rr.dout", dout, (k % 4 == 1) ? 32'h0F : 32'hFF);
      end
    end
    tick();
    pulses("rr.idle", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
